alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU succeeding the 8-bit single-cycle ALU on the processor's data bus. Adds a start/busy/done handshake, carry-chained add/subtract, arithmetic shift and rotate, multi-bit shifts, and an optional iterative multiplier. Result and flags are registered. The result drives the shared bus through a tri-state output.

## Interface
- WIDTH, 8, operand/result width; ≥4, power of two
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_A  in  WIDTH  operand A
- in_B  in  WIDTH  operand B; multi-bit shifts use the low log2(WIDTH) bits
- op  in  4  operation code, sampled with in_start
- in_start  in  1  request; sampled only when busy=0
- in_enable_out  in  1  1 drives `out`; 0 tri-states it
- out  out  WIDTH  registered result, or 'z when in_enable_out=0
- out_hi  out  WIDTH  high half of the last product; 0 after any other op
- flags  out  4  {C, N, O, Z}, registered
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when result and flags commit

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 OR, 3 AND, 4 NOT A, 5 CMP (result 1 if A==B, else 0)
  - 6 SHR1, 7 SHL1, 8 ADC (A+B+C), 9 SBB (A−B−C), 10 ASR1, 11 ROL1, 12 ROR1
  - 13 MUL, 14 SHLN (A<<n), 15 SHRN (A>>n); n = in_B[log2(WIDTH)-1:0]
- Arithmetic runs at WIDTH+1 bits, zero-extended. C is bit WIDTH. For SUB/SBB, C=1 means borrow (A < B+cin).
- ADC/SBB use the registered C flag as it stood when in_start was sampled.
- O = two's-complement overflow for ADD/ADC (same-sign operands, result sign differs) and SUB/SBB (operand signs differ, result sign ≠ A sign).
- For shifts and rotates, C = last bit shifted out; 0 when n=0. For MUL, C = O = (out_hi ≠ 0). For all other ops, C = O = 0.
- N = result[WIDTH-1]; Z = (result == 0).
- FSM states: IDLE, ITER.
  - IDLE with in_start: ops 0–12 commit in the same edge, state stays IDLE. Ops 13–15 latch operands, load cnt (WIDTH for MUL, n for shifts), set busy, go to ITER.
  - ITER each edge: if cnt=0, commit, pulse done, clear busy, go to IDLE. Otherwise do one shift-add or one 1-bit shift, cnt−1.
- in_start while busy=1 is ignored; no queueing.
- Result, out_hi and flags hold between commits.
- rst at any time, including during ITER: state IDLE, result 0, out_hi 0, flags 0000, busy 0, done 0, cnt 0. The in-flight op is discarded.

## Timing
- Single-cycle ops: in_start sampled at edge k. Result, flags and done=1 are visible after edge k. done drops after edge k+1 unless another start is sampled at k+1, which allows back-to-back starts.
- SHLN/SHRN: busy=1 after edge k. done pulses after edge k+n+1. n=0 takes 1 extra cycle.
- MUL: done after edge k+WIDTH+1.
- `out` is combinational from the result register and in_enable_out: 'z when in_enable_out=0, with no cycle delay.

## Configuration
- ALU_MUL_EN defined: op 13 is the iterative unsigned multiplier described above.
- ALU_MUL_EN undefined: op 13 commits in one cycle with result 0, out_hi 0, flags 0001. No multiplier logic is built.

## Structure
- Package alu_pkg holds:
  - op code localparams
  - FSM state encoding
  - flag bit indices C=3, N=2, O=1, Z=0
- Sub-module alu_iter holds the shift/shift-add datapath and cnt: load, step, zero-count. alu_mc holds the FSM, single-cycle ops, flag logic and tri-state.

## Test plan
- WIDTH=8. ADD 0x7F+0x01 → after 1 edge: out=0x80, flags C0 N1 O1 Z0, done=1 for one cycle.
- SUB 0x00−0x01, then ADC 0x00+0x00 → first: out=0xFF, C=1, N=1. Second: out=0x01 (uses C=1).
- SHLN A=0x81, B=3 → busy for 3 cycles, done after edge 4: out=0x08, C=0. Repeat with B=0 → done after edge 1, out=0x81, C=0.
- MUL 0x10×0x20 (ALU_MUL_EN) → done after edge 9: out=0x00, out_hi=0x02, C=1, Z=1.
- During MUL, raise in_start with op=ADD at cycle 3 → ignored, final MUL result unchanged. Then assert rst at cycle 5 of a second MUL → next edge busy=0, done=0, out=0, flags=0000.
- in_enable_out=0 → out='z. Set to 1 → out equals the last committed result in the same cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM and iterator encodings, and flag bit positions shared by alu_mc and alu_iter.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_OR   = 4'd2,  OP_AND  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4,  OP_CMP  = 4'd5,  OP_SHR1 = 4'd6,  OP_SHL1 = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8,  OP_SBB  = 4'd9,  OP_ASR1 = 4'd10, OP_ROL1 = 4'd11;
  localparam logic [3:0] OP_ROR1 = 4'd12, OP_MUL  = 4'd13, OP_SHLN = 4'd14, OP_SHRN = 4'd15;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {ST_IDLE, ST_ITER} state_e;

  typedef enum logic [1:0] {IT_SHL, IT_SHR, IT_MUL} iter_mode_e;

endpackage

// File: rtl/alu_iter.sv
// alu_iter: iteration counter plus 1-bit shifter and shift-add multiplier datapath for alu_mc.
// The multiplier path exists only when ALU_MUL_EN is defined.
module alu_iter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SH_W  = $clog2(WIDTH),
  localparam int CNT_W = SH_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  iter_mode_e       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             zero,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             carry
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             carry_q, carry_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   psum;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    carry_d = carry_q;
`ifdef ALU_MUL_EN
    hi_d    = hi_q;
    mcand_d = mcand_q;
    psum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
`endif
    if (load) begin
      cnt_d   = CNT_W'(b[SH_W-1:0]);
      lo_d    = a;
      carry_d = 1'b0;
`ifdef ALU_MUL_EN
      // The multiplier sits in lo and is consumed LSB-first as the product fills hi:lo.
      if (mode == IT_MUL) begin
        cnt_d = CNT_W'(WIDTH);
        lo_d  = b;
      end
      hi_d    = '0;
      mcand_d = a;
`endif
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
      case (mode)
        IT_SHL: begin
          carry_d = lo_q[WIDTH-1];
          lo_d    = {lo_q[WIDTH-2:0], 1'b0};
        end
        IT_SHR: begin
          carry_d = lo_q[0];
          lo_d    = {1'b0, lo_q[WIDTH-1:1]};
        end
`ifdef ALU_MUL_EN
        IT_MUL: {hi_d, lo_d} = {psum, lo_q[WIDTH-1:1]};
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge clk) begin
    lo_q <= lo_d;
`ifdef ALU_MUL_EN
    hi_q    <= hi_d;
    mcand_q <= mcand_d;
`endif
  end

  assign zero  = (cnt_q == '0);
  assign lo    = lo_q;
  assign carry = carry_q;
`ifdef ALU_MUL_EN
  assign hi = hi_q;
`else
  assign hi = '0;
`endif

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with start/busy/done handshake, registered result/flags and tri-state bus output.
// Define ALU_MUL_EN to build the iterative multiplier for op 13; otherwise op 13 commits zero in one cycle.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [3:0]       op,
  input  logic             in_start,
  input  logic             in_enable_out,
  output wire logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  iter_mode_e       mode_q, mode_d, it_mode, new_mode;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             it_load, it_step, it_zero, it_carry, iter_op;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic [WIDTH:0]   a_x, b_x, cin_x, sum;
  logic signed [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_o;

  function automatic logic [3:0] make_flags(input logic c, input logic o, input logic [WIDTH-1:0] r);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_O] = o;
    f[FLAG_Z] = (r == '0);
    return f;
  endfunction

  // Single-cycle ops; add/sub run zero-extended at WIDTH+1 bits so bit WIDTH is carry/borrow.
  always_comb begin
    a_x    = {1'b0, in_A};
    b_x    = {1'b0, in_B};
    cin_x  = {{WIDTH{1'b0}}, flags_q[FLAG_C]};
    a_s    = in_A;
    sum    = '0;
    sc_res = '0;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        sum    = a_x + b_x + ((op == OP_ADC) ? cin_x : '0);
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_o   = (in_A[WIDTH-1] == in_B[WIDTH-1]) && (sc_res[WIDTH-1] != in_A[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        sum    = a_x - b_x - ((op == OP_SBB) ? cin_x : '0);
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_o   = (in_A[WIDTH-1] != in_B[WIDTH-1]) && (sc_res[WIDTH-1] != in_A[WIDTH-1]);
      end
      OP_OR:   sc_res = in_A | in_B;
      OP_AND:  sc_res = in_A & in_B;
      OP_NOT:  sc_res = ~in_A;
      OP_CMP:  sc_res = WIDTH'(in_A == in_B);
      OP_SHR1: begin
        sc_res = {1'b0, in_A[WIDTH-1:1]};
        sc_c   = in_A[0];
      end
      OP_SHL1: {sc_c, sc_res} = {in_A, 1'b0};
      OP_ASR1: begin
        sc_res = a_s >>> 1;
        sc_c   = in_A[0];
      end
      OP_ROL1: begin
        sc_res = {in_A[WIDTH-2:0], in_A[WIDTH-1]};
        sc_c   = in_A[WIDTH-1];
      end
      OP_ROR1: begin
        sc_res = {in_A[0], in_A[WIDTH-1:1]};
        sc_c   = in_A[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    result_d = result_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    it_load  = 1'b0;
    it_step  = 1'b0;
    it_mode  = mode_q;
    iter_op  = 1'b0;
    new_mode = IT_SHL;
    case (op)
      OP_SHLN: iter_op = 1'b1;
      OP_SHRN: begin
        iter_op  = 1'b1;
        new_mode = IT_SHR;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        iter_op  = 1'b1;
        new_mode = IT_MUL;
      end
`endif
      default: ;
    endcase
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          if (iter_op) begin
            it_load = 1'b1;
            it_mode = new_mode;
            mode_d  = new_mode;
            busy_d  = 1'b1;
            state_d = ST_ITER;
          end else begin
            result_d = sc_res;
            hi_d     = '0;
            flags_d  = make_flags(sc_c, sc_o, sc_res);
            done_d   = 1'b1;
          end
        end
      end
      ST_ITER: begin
        if (it_zero) begin
          result_d = it_lo;
          hi_d     = it_hi;
          if (mode_q == IT_MUL) flags_d = make_flags(|it_hi, |it_hi, it_lo);
          else                  flags_d = make_flags(it_carry, 1'b0, it_lo);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          it_step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= IT_SHL;
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .load  (it_load),
    .step  (it_step),
    .mode  (it_mode),
    .a     (in_A),
    .b     (in_B),
    .zero  (it_zero),
    .lo    (it_lo),
    .hi    (it_hi),
    .carry (it_carry)
  );

  assign out    = in_enable_out ? result_q : {WIDTH{1'bz}};
  assign out_hi = hi_q;
  assign flags  = flags_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=8 (multiplier checks follow ALU_MUL_EN).
module tb_alu_mc;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, ORR = 4'd2, ANDD = 4'd3, NOTA = 4'd4, CMP = 4'd5;
  localparam logic [3:0] SHR1 = 4'd6, SHL1 = 4'd7, ADC = 4'd8, SBB = 4'd9, ASR1 = 4'd10;
  localparam logic [3:0] ROL1 = 4'd11, ROR1 = 4'd12, MUL = 4'd13, SHLN = 4'd14, SHRN = 4'd15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_A, in_B;
  logic [3:0] op;
  logic       in_start, in_enable_out;
  wire  [7:0] out_w;
  logic [7:0] out_hi;
  logic [3:0] flags;
  logic       busy, done;
  logic       drv_en;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  // A second bus master, used to show the ALU really releases the shared bus.
  assign out_w = drv_en ? 8'h5A : 8'hzz;

  alu_mc #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_A          (in_A),
    .in_B          (in_B),
    .op            (op),
    .in_start      (in_start),
    .in_enable_out (in_enable_out),
    .out           (out_w),
    .out_hi        (out_hi),
    .flags         (flags),
    .busy          (busy),
    .done          (done)
  );

  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op = o; in_A = a; in_B = b; in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_w !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", out_w); end
    checks++; if (out_hi !== 8'h00) begin failures++; $display("FAIL reset_out_hi got=%h exp=00", out_hi); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    issue(ADD, 8'h7F, 8'h01);
    checks++; if (out_w !== 8'h80) begin failures++; $display("FAIL add_out got=%h exp=80", out_w); end
    checks++; if (flags !== 4'b0110) begin failures++; $display("FAIL add_flags got=%b exp=0110", flags); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_drop got=%b exp=0", done); end
    checks++; if (out_w !== 8'h80) begin failures++; $display("FAIL add_hold got=%h exp=80", out_w); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op = SUB; in_A = 8'h00; in_B = 8'h01; in_start = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_w !== 8'hFF) begin failures++; $display("FAIL b2b_sub_out got=%h exp=ff", out_w); end
    checks++; if (flags !== 4'b1100) begin failures++; $display("FAIL b2b_sub_flags got=%b exp=1100", flags); end
    op = ADC; in_A = 8'h00; in_B = 8'h00;
    @(posedge clk); #1;
    in_start = 1'b0;
    checks++; if (out_w !== 8'h01) begin failures++; $display("FAIL b2b_adc_out got=%h exp=01", out_w); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL b2b_adc_flags got=%b exp=0000", flags); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_adc_done got=%b exp=1", done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
  endtask

  task automatic test_single_cycle();
    logic [3:0] t_op [0:15];
    logic [7:0] t_a [0:15];
    logic [7:0] t_b [0:15];
    logic [7:0] t_out [0:15];
    logic [3:0] t_fl [0:15];
    t_op  = '{ORR,   ANDD,  NOTA,  CMP,   CMP,   SHR1,  SHL1,  ASR1,
              ROL1,  ROR1,  SUB,   ADD,   ADC,   SUB,   SBB,   SBB};
    t_a   = '{8'hF0, 8'hF0, 8'h0F, 8'h33, 8'h33, 8'h01, 8'h81, 8'h81,
              8'h81, 8'h81, 8'h80, 8'hFF, 8'h10, 8'h00, 8'h05, 8'h00};
    t_b   = '{8'h0F, 8'h0F, 8'h00, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h01, 8'h01, 8'h20, 8'h01, 8'h02, 8'h00};
    t_out = '{8'hFF, 8'h00, 8'hF0, 8'h01, 8'h00, 8'h00, 8'h02, 8'hC0,
              8'h03, 8'hC0, 8'h7F, 8'h00, 8'h31, 8'hFF, 8'h02, 8'h00};
    t_fl  = '{4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b1001, 4'b1000, 4'b1100,
              4'b1000, 4'b1100, 4'b0010, 4'b1001, 4'b0000, 4'b1100, 4'b0000, 4'b0001};
    for (int i = 0; i < 16; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      checks++;
      if (out_w !== t_out[i]) begin
        failures++; $display("FAIL single_out row=%0d op=%0d got=%h exp=%h", i, t_op[i], out_w, t_out[i]);
      end
      checks++;
      if (flags !== t_fl[i]) begin
        failures++; $display("FAIL single_flags row=%0d op=%0d got=%b exp=%b", i, t_op[i], flags, t_fl[i]);
      end
      checks++;
      if (done !== 1'b1) begin
        failures++; $display("FAIL single_done row=%0d got=%b exp=1", i, done);
      end
    end
  endtask

  task automatic test_multi_shift();
    int edges;
    issue(SHLN, 8'h81, 8'h03);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL shln_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL shln_early_done got=%b exp=0", done); end
    wait_done(20, edges);
    checks++; if (edges != 4) begin failures++; $display("FAIL shln_latency got=%0d exp=4", edges); end
    checks++; if (out_w !== 8'h08) begin failures++; $display("FAIL shln_out got=%h exp=08", out_w); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL shln_flags got=%b exp=0000", flags); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL shln_busy_clr got=%b exp=0", busy); end
    issue(SHLN, 8'h81, 8'h00);
    wait_done(20, edges);
    checks++; if (edges != 1) begin failures++; $display("FAIL shln0_latency got=%0d exp=1", edges); end
    checks++; if (out_w !== 8'h81) begin failures++; $display("FAIL shln0_out got=%h exp=81", out_w); end
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL shln0_flags got=%b exp=0100", flags); end
    issue(SHRN, 8'h81, 8'h01);
    wait_done(20, edges);
    checks++; if (edges != 2) begin failures++; $display("FAIL shrn_latency got=%0d exp=2", edges); end
    checks++; if (out_w !== 8'h40) begin failures++; $display("FAIL shrn_out got=%h exp=40", out_w); end
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL shrn_flags got=%b exp=1000", flags); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    int edges;
    issue(MUL, 8'h10, 8'h20);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        op = ADD; in_A = 8'h01; in_B = 8'h01; in_start = 1'b1;
      end else begin
        in_start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        edges = i;
        break;
      end
    end
    in_start = 1'b0;
    checks++; if (edges != 9) begin failures++; $display("FAIL mul_latency got=%0d exp=9", edges); end
    checks++; if (out_w !== 8'h00) begin failures++; $display("FAIL mul_out got=%h exp=00", out_w); end
    checks++; if (out_hi !== 8'h02) begin failures++; $display("FAIL mul_out_hi got=%h exp=02", out_hi); end
    checks++; if (flags !== 4'b1011) begin failures++; $display("FAIL mul_flags got=%b exp=1011", flags); end
    issue(ADD, 8'h01, 8'h01);
    checks++; if (out_hi !== 8'h00) begin failures++; $display("FAIL mul_hi_clear got=%h exp=00", out_hi); end
    checks++; if (out_w !== 8'h02) begin failures++; $display("FAIL mul_then_add got=%h exp=02", out_w); end
  endtask
`else
  task automatic test_mul();
    issue(MUL, 8'h10, 8'h20);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mul_off_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_off_busy got=%b exp=0", busy); end
    checks++; if (out_w !== 8'h00) begin failures++; $display("FAIL mul_off_out got=%h exp=00", out_w); end
    checks++; if (out_hi !== 8'h00) begin failures++; $display("FAIL mul_off_hi got=%h exp=00", out_hi); end
    checks++; if (flags !== 4'b0001) begin failures++; $display("FAIL mul_off_flags got=%b exp=0001", flags); end
  endtask
`endif

  task automatic test_reset_midop();
    logic saw_done;
`ifdef ALU_MUL_EN
    issue(MUL, 8'h10, 8'h20);
`else
    issue(SHLN, 8'h81, 8'h07);
`endif
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (out_w !== 8'h00) begin failures++; $display("FAIL midrst_out got=%h exp=00", out_w); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL midrst_flags got=%b exp=0000", flags); end
    checks++; if (out_hi !== 8'h00) begin failures++; $display("FAIL midrst_hi got=%h exp=00", out_hi); end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midrst_discard got=%b exp=0", saw_done); end
  endtask

  task automatic test_tristate();
    issue(ADD, 8'h80, 8'h01);
    in_enable_out = 1'b0;
    drv_en = 1'b1;
    #1;
    checks++; if (out_w !== 8'h5A) begin failures++; $display("FAIL tri_release got=%h exp=5a", out_w); end
    drv_en = 1'b0;
    in_enable_out = 1'b1;
    #1;
    checks++; if (out_w !== 8'h81) begin failures++; $display("FAIL tri_drive got=%h exp=81", out_w); end
  endtask

  initial begin
    rst = 1'b1; in_A = '0; in_B = '0; op = '0; in_start = 1'b0;
    in_enable_out = 1'b1; drv_en = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_single_cycle();
    test_multi_shift();
    test_mul();
    test_reset_midop();
    test_tristate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
